// File: rtl/titan_fetch_pkg.sv
// titan_fetch_pkg: shared state encoding, pc select codes and default nop for the fetch controller
package titan_fetch_pkg;
  typedef enum logic [1:0] {ST_ISSUE, ST_REQ, ST_DISCARD, ST_VALID} fetch_state_e;
  localparam logic [1:0] PC_SEL_SEQ = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_JUMP = 2'd2;
  localparam logic [1:0] PC_SEL_EXC = 2'd3;
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;
endpackage

// File: rtl/titan_pc_sel_arb.sv
// titan_pc_sel_arb: priority encoder exception > jump > branch > sequential into pc select plus redirect flag
module titan_pc_sel_arb
  import titan_fetch_pkg::*;
(
  input  logic       exception,
  input  logic       jump,
  input  logic       branch,
  output logic [1:0] pc_sel,
  output logic       redirect
);
  always_comb begin
    pc_sel = exception ? PC_SEL_EXC : jump ? PC_SEL_JUMP : branch ? PC_SEL_BRANCH : PC_SEL_SEQ;
    redirect = exception | jump | branch;
  end
endmodule

// File: rtl/titan_fetch_ctrl.sv
// titan_fetch_ctrl: instruction fetch sequencer driving the bus master, holding the word for decode and generating if stall/flush
module titan_fetch_ctrl
  import titan_fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] if_pc_i,
  input  logic        id_stall_i,
  input  logic        branch_taken_i,
  input  logic        jump_i,
  input  logic        exception_i,
  output logic [1:0]  pc_sel_o,
  output logic        if_stall_o,
  output logic        if_flush_o,
  output logic [31:0] if_instruction_o,
  output logic        if_inst_access_fault_o,
  output logic        if_inst_addr_misaligned_o,
  output logic [31:0] iport_addr_o,
  output logic        iport_cyc_o,
  output logic        iport_stb_o,
  input  logic [31:0] iport_data_i,
  input  logic        iport_ack_i,
  input  logic        iport_err_i
);
  fetch_state_e state, state_d;
  logic redirect, tmo, done, cyc_d, stb_d, fault_d, misal_d;
  logic [31:0] addr_d, instr_d, cnt, cnt_d;
  titan_pc_sel_arb u_arb (
    .exception(exception_i),
    .jump     (jump_i),
    .branch   (branch_taken_i),
    .pc_sel   (pc_sel_o),
    .redirect (redirect)
  );
  always_comb begin
    tmo = (TIMEOUT_CYCLES != 0) && (cnt == TIMEOUT_CYCLES - 32'd1);
    done = iport_ack_i | iport_err_i | tmo;
    if_flush_o = redirect;
    if_stall_o = !redirect && (state != ST_VALID || id_stall_i);
    state_d = state;
    cyc_d = iport_cyc_o;
    stb_d = iport_stb_o;
    addr_d = iport_addr_o;
    instr_d = if_instruction_o;
    fault_d = if_inst_access_fault_o;
    misal_d = if_inst_addr_misaligned_o;
    cnt_d = cnt + 32'd1;
    case (state)
      ST_ISSUE: begin
        cnt_d = '0;
        if (!redirect && if_pc_i[1:0] != 2'b00) begin
          state_d = ST_VALID;
          instr_d = NOP_INSTR;
          misal_d = 1'b1;
          fault_d = 1'b0;
        end else if (!redirect) begin
          state_d = ST_REQ;
          cyc_d = 1'b1;
          stb_d = 1'b1;
          addr_d = {if_pc_i[31:2], 2'b00};
        end
      end
      ST_REQ: begin
        if (redirect) begin
          // an unanswered request must still be drained, so keep cyc and restart the timeout
          state_d = done ? ST_ISSUE : ST_DISCARD;
          cyc_d = !done;
          stb_d = 1'b0;
          cnt_d = '0;
        end else if (done) begin
          state_d = ST_VALID;
          cyc_d = 1'b0;
          stb_d = 1'b0;
          instr_d = iport_ack_i ? iport_data_i : NOP_INSTR;
          fault_d = !iport_ack_i;
          misal_d = 1'b0;
        end
      end
      ST_DISCARD: begin
        if (done) begin
          state_d = ST_ISSUE;
          cyc_d = 1'b0;
        end
      end
      ST_VALID: begin
        if (redirect || !id_stall_i) begin
          state_d = ST_ISSUE;
          fault_d = 1'b0;
          misal_d = 1'b0;
        end
      end
      default: state_d = ST_ISSUE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= ST_ISSUE;
      iport_cyc_o <= 1'b0;
      iport_stb_o <= 1'b0;
      iport_addr_o <= '0;
      if_instruction_o <= NOP_INSTR;
      if_inst_access_fault_o <= 1'b0;
      if_inst_addr_misaligned_o <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_d;
      iport_cyc_o <= cyc_d;
      iport_stb_o <= stb_d;
      iport_addr_o <= addr_d;
      if_instruction_o <= instr_d;
      if_inst_access_fault_o <= fault_d;
      if_inst_addr_misaligned_o <= misal_d;
      cnt <= cnt_d;
    end
  end
endmodule

// File: tb/tb_titan_fetch_ctrl.sv
// tb_titan_fetch_ctrl: scoreboard bench with a bus slave, a pc register model and an instruction-stream reference
module tb_titan_fetch_ctrl;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct packed {logic [31:0] ins; logic flt; logic mis;} exp_t;
  logic clk = 0, rst_n = 0;
  logic [31:0] if_pc = 0, br_tgt = 0, jmp_tgt = 0, exc_tgt = 0, pc_nxt = 0;
  logic id_stall = 0, br = 0, jmp = 0, exc = 0;
  logic [1:0] pc_sel, ms;
  logic if_stall, if_flush, fault, misal, cyc, stb, ack = 0, err = 0, pend = 0, saw = 0, noack = 0;
  logic [31:0] instr, addr, rdata = 0, sa = 0;
  int errors = 0, checks = 0, accepts = 0, lat_cfg = 0, lat = 0, n = 0;
  exp_t q[$];
  exp_t me;
  always #5 clk = ~clk;
  titan_fetch_ctrl dut (
    .clk_i(clk), .rst_i(rst_n), .if_pc_i(if_pc), .id_stall_i(id_stall),
    .branch_taken_i(br), .jump_i(jmp), .exception_i(exc), .pc_sel_o(pc_sel),
    .if_stall_o(if_stall), .if_flush_o(if_flush), .if_instruction_o(instr),
    .if_inst_access_fault_o(fault), .if_inst_addr_misaligned_o(misal),
    .iport_addr_o(addr), .iport_cyc_o(cyc), .iport_stb_o(stb),
    .iport_data_i(rdata), .iport_ack_i(ack), .iport_err_i(err)
  );
  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h0050_0093 + (a << 8);
  endfunction
  function automatic logic is_err(input logic [31:0] a);
    return a[11:8] == 4'h2;
  endfunction
  function automatic exp_t expect_at(input logic [31:0] p);
    exp_t e;
    e.mis = p[1:0] != 2'b00;
    e.flt = !e.mis && (noack || is_err(p));
    e.ins = (e.mis || e.flt) ? NOP : mem(p);
    return e;
  endfunction
  function automatic logic [31:0] rand_tgt();
    logic [31:0] t = 32'($urandom_range(0, 4095));
    if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
    return t;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic apply_reset();
    rst_n = 0;
    pc_nxt = 0;
    if_pc = 0;
    q.delete();
    q.push_back(expect_at(32'h0));
  endtask
  task automatic wait_fetch(input logic [31:0] a);
    int k = 0;
    while (!(cyc && stb) && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("fetch_addr", k < 60 ? addr : 32'hdead_beef, a);
  endtask
  // bus slave: latches a request on stb, answers after lat cycles while cyc stays up
  initial forever begin
    @(posedge clk);
    #1;
    ack = 0;
    err = 0;
    if (!cyc) pend = 0;
    else if (!pend && stb) begin
      pend = 1;
      lat = (lat_cfg < 0) ? int'($urandom_range(0, 4)) : lat_cfg;
      sa = addr;
    end
    if (pend && !noack) begin
      if (lat == 0) begin
        pend = 0;
        if (is_err(sa)) err = 1;
        else begin
          ack = 1;
          rdata = mem(sa);
        end
      end else lat--;
    end
  end
  // pc register model loads the value chosen on the previous negedge
  initial forever begin
    @(posedge clk);
    #1;
    if (rst_n) if_pc = pc_nxt;
  end
  // monitor: redirects flush the scoreboard, accepted words are popped and compared
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (exc || jmp || br) begin
        ms = exc ? 2'd3 : jmp ? 2'd2 : 2'd1;
        chk("pc_sel", 32'(pc_sel), 32'(ms));
        chk("redirect_flush_stall", 32'({if_flush, if_stall}), 32'b10);
        pc_nxt = ms == 2'd3 ? exc_tgt : ms == 2'd2 ? jmp_tgt : br_tgt;
        q.delete();
        q.push_back(expect_at(pc_nxt));
      end else begin
        chk("idle_sel_flush", 32'({pc_sel, if_flush}), 32'b0);
        if (!if_stall) begin
          accepts++;
          if (q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL sb_empty: word %h delivered with nothing expected", instr);
          end else begin
            me = q.pop_front();
            chk("sb_instr", instr, me.ins);
            chk("sb_fault", 32'(fault), 32'(me.flt));
            chk("sb_misal", 32'(misal), 32'(me.mis));
          end
          pc_nxt = if_pc + 32'd4;
          q.push_back(expect_at(pc_nxt));
        end
      end
    end
  end
  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog: run did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
  initial begin
    apply_reset();
    repeat (2) @(negedge clk);
    chk("rst_cyc_stb", 32'({cyc, stb}), 32'b0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_instr", instr, NOP);
    chk("rst_flags_flush", 32'({fault, misal, if_flush}), 32'b0);
    chk("rst_stall_sel", 32'({if_stall, pc_sel}), 32'b100);
    @(posedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    chk("issue_idle", 32'({cyc, if_stall}), 32'b01);
    @(negedge clk);
    chk("first_fetch", 32'({cyc, stb}), 32'b11);
    chk("first_addr", addr, 32'h0);
    @(negedge clk);
    chk("first_word", instr, 32'h0050_0093);
    chk("valid_stall", 32'(if_stall), 32'b0);
    @(negedge clk);
    chk("issue_stall", 32'(if_stall), 32'b1);
    @(posedge clk);
    #1;
    id_stall = 1;
    @(negedge clk);
    chk("second_addr", addr, 32'h4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_stall", 32'({if_stall, cyc}), 32'b10);
      chk("hold_instr", instr, mem(32'h4));
    end
    @(posedge clk);
    #1;
    id_stall = 0;
    lat_cfg = 3;
    @(negedge clk);
    chk("release_stall", 32'(if_stall), 32'b0);
    repeat (2) @(negedge clk);
    chk("resume_addr", addr, 32'h8);
    @(posedge clk);
    #1;
    br_tgt = 32'h100;
    br = 1;
    @(negedge clk);
    chk("branch_sel_flush", 32'({if_flush, pc_sel}), 32'b101);
    @(posedge clk);
    #1;
    br = 0;
    @(negedge clk);
    chk("discard_cyc_stb", 32'({cyc, stb, if_flush}), 32'b100);
    wait_fetch(32'h100);
    lat_cfg = 0;
    @(posedge clk);
    #1;
    exc_tgt = 32'h200;
    jmp_tgt = 32'h180;
    exc = 1;
    jmp = 1;
    @(negedge clk);
    chk("exc_jump_sel", 32'({if_flush, pc_sel}), 32'b111);
    @(posedge clk);
    #1;
    exc = 0;
    jmp = 0;
    @(negedge clk);
    wait_fetch(32'h200);
    n = 0;
    while (!fault && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("err_flags", 32'({fault, misal}), 32'b10);
    chk("err_nop", instr, NOP);
    @(posedge clk);
    #1;
    noack = 1;
    jmp_tgt = 32'h300;
    jmp = 1;
    @(posedge clk);
    #1;
    jmp = 0;
    @(negedge clk);
    wait_fetch(32'h300);
    n = 0;
    while (cyc && stb && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_req_cycles", 32'(n), 32'd16);
    chk("timeout_flags", 32'({fault, misal}), 32'b10);
    @(posedge clk);
    #1;
    noack = 0;
    br_tgt = 32'h102;
    br = 1;
    @(posedge clk);
    #1;
    br = 0;
    n = 0;
    saw = 0;
    while (!misal && n < 20) begin
      @(negedge clk);
      n++;
      saw = saw | cyc | stb;
    end
    chk("misal_no_bus", 32'(saw), 32'b0);
    chk("misal_flags", 32'({fault, misal}), 32'b01);
    chk("misal_nop", instr, NOP);
    @(posedge clk);
    #1;
    jmp_tgt = 32'h400;
    jmp = 1;
    lat_cfg = 6;
    @(posedge clk);
    #1;
    jmp = 0;
    @(negedge clk);
    wait_fetch(32'h400);
    #2;
    apply_reset();
    #1;
    chk("async_rst_bus", 32'({cyc, stb}), 32'b0);
    chk("async_rst_addr", addr, 32'h0);
    chk("async_rst_instr", instr, NOP);
    chk("async_rst_ctrl", 32'({if_stall, if_flush, fault, misal, pc_sel}), 32'b100000);
    @(posedge clk);
    #1;
    rst_n = 1;
    lat_cfg = -1;
    repeat (600) begin
      @(posedge clk);
      #1;
      id_stall = $urandom_range(0, 3) == 0;
      br = $urandom_range(0, 15) == 0;
      jmp = $urandom_range(0, 31) == 0;
      exc = $urandom_range(0, 63) == 0;
      br_tgt = rand_tgt();
      jmp_tgt = rand_tgt();
      exc_tgt = rand_tgt();
    end
    @(posedge clk);
    #1;
    {br, jmp, exc, id_stall} = 4'b0;
    repeat (20) @(negedge clk);
    chk("progress", 32'(accepts >= 20), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/titan_fetch_ctrl.md
Name: titan_fetch_ctrl

Overview:
Sequences the instruction fetch path: drives the instruction bus master port, holds the fetched word until decode accepts it, and generates the IF stall/flush controls. Arbitrates the four PC sources (sequential, branch, jump, exception) into a 2-bit PC select. Sits between the PC register/PC source mux, the IF/ID register and the instruction memory bus.

Parameters:
TIMEOUT_CYCLES, 16, bus cycles to wait for ack/err before flagging an access fault; 0 disables the timeout.
NOP_INSTR, 32'h0000_0013, word presented to decode on a fault or misaligned fetch.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous active-low reset.
if_pc_i  in  32  current PC register value.
id_stall_i  in  1  decode cannot accept an instruction.
branch_taken_i  in  1  redirect to branch target.
jump_i  in  1  redirect to jump target.
exception_i  in  1  redirect to exception PC.
pc_sel_o  out  2  PC source select: 0 = pc+4, 1 = branch, 2 = jump, 3 = exception.
if_stall_o  out  1  hold the PC register and the IF side of IF/ID.
if_flush_o  out  1  insert a bubble into IF/ID.
if_instruction_o  out  32  instruction to IF/ID.
if_inst_access_fault_o  out  1  fetch ended in err or timeout.
if_inst_addr_misaligned_o  out  1  fetch PC[1:0] != 0.
iport_addr_o  out  32  bus address, word-aligned.
iport_cyc_o  out  1  bus cycle active.
iport_stb_o  out  1  bus strobe.
iport_data_i  in  32  bus read data.
iport_ack_i  in  1  bus acknowledge.
iport_err_i  in  1  bus error.

Behaviour:
- Reset (async, rst_i=0): state=ISSUE; cyc/stb=0; iport_addr_o=0; if_instruction_o=NOP_INSTR; both fault flags=0; if_stall_o=1; if_flush_o=0; pc_sel_o=0; timeout counter=0. Any in-flight bus cycle is dropped immediately.
- Redirect = exception_i | jump_i | branch_taken_i. Priority: exception > jump > branch > sequential. pc_sel_o is combinational from this priority and is 0 when there is no redirect.
- A redirect forces if_stall_o=0 and if_flush_o=1 in that same cycle, in every state, so the PC loads the target and IF/ID takes a bubble.
- ISSUE:
  - Redirect: stay in ISSUE.
  - if_pc_i[1:0] != 0: no bus cycle; load NOP_INSTR, set misaligned=1, go to VALID.
  - Otherwise: register cyc=stb=1 and addr=if_pc_i, clear the counter, go to REQ.
  - if_stall_o=1 unless a redirect is active.
- REQ:
  - cyc/stb stay high and the counter increments each cycle.
  - ack with no redirect: latch iport_data_i, fault=0, drop cyc/stb, go to VALID.
  - err, or counter==TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES != 0: load NOP_INSTR, fault=1, drop cyc/stb, go to VALID.
  - Redirect together with ack/err: redirect wins; data is discarded, cyc/stb drop, go to ISSUE.
  - Redirect without ack/err: go to DISCARD.
- DISCARD: keep cyc=1, stb=0 until ack/err, discard the response, then go to ISSUE. A further redirect in DISCARD updates the PC and stays in DISCARD. The timeout also applies here; on expiry go to ISSUE with no fault.
- VALID:
  - if_instruction_o and the fault flags are held stable.
  - if_stall_o = id_stall_i.
  - id_stall_i=0: IF/ID captures the word and the PC advances (pc+4); go to ISSUE and clear the flags next cycle.
  - Redirect: drop the word, go to ISSUE.
- Minimum throughput is one instruction per 3 cycles (ISSUE, REQ with zero-wait ack, VALID).
- Fault flags are mutually exclusive and are valid only in VALID.

Decomposition:
- Package titan_fetch_pkg: state encoding (ISSUE, REQ, DISCARD, VALID), PC_SEL_SEQ/BRANCH/JUMP/EXC constants, default NOP.
- Sub-module titan_pc_sel_arb: combinational priority encoder from the three redirect requests to pc_sel_o plus a redirect flag.
- The FSM, timeout counter and instruction buffer stay in titan_fetch_ctrl.

Test Plan:
- Reset release, if_pc_i=0x0, zero-wait memory returns 0x00500093 -> cyc asserted the cycle after reset, addr=0x0; if_instruction_o=0x00500093 in VALID; if_stall_o=0 one cycle; next fetch addr=0x4.
- id_stall_i held 4 cycles in VALID -> if_stall_o=1 for those 4 cycles, instruction held, no new cyc; resumes the cycle after release.
- Redirect during REQ: branch_taken_i=1 while waiting (ack 3 cycles later), target 0x100 -> pc_sel_o=1, if_flush_o=1 for 1 cycle; DISCARD drops the late data; next addr=0x100.
- exception_i=1 and jump_i=1 together -> pc_sel_o=3; if_flush_o=1.
- iport_err_i on fetch of 0x200 -> VALID with if_instruction_o=0x00000013, access_fault=1. No-ack memory with TIMEOUT_CYCLES=16 -> fault after exactly 16 REQ cycles.
- Misaligned target 0x102 -> no cyc; misaligned=1 with NOP. rst_i low mid-REQ -> cyc drops asynchronously; all outputs at reset values.
